// File: rtl/reset_pkg.sv
// Shared types and constants for the reset sequencer: FSM states and cause-register bit indices.
package reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned CAUSE_POR  = 0;
  localparam int unsigned CAUSE_WDT  = 1;
  localparam int unsigned CAUSE_TRAP = 2;
  localparam int unsigned CAUSE_SOFT = 3;

endpackage

// File: rtl/reset_cause_reg.sv
// Reset-cause register: restart/accumulate on reset requests, write-1-to-clear from the I/O bus,
// with a set in the same cycle taking priority over a clear of the same bit.
module reset_cause_reg
  import reset_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic [CAUSE_W-1:0] set_bits,
  input  logic               clear_en,
  input  logic [CAUSE_W-1:0] clear_mask,
  output logic [7:0]         cause_out
);

  localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1) << CAUSE_POR;

  logic [CAUSE_W-1:0] cause_q;
  logic [CAUSE_W-1:0] cause_d;

  // Clear first, then wipe on a fresh sequence, then apply sets so sets always win.
  always_comb begin
    cause_d = cause_q;
    if (clear_en) begin
      cause_d = cause_d & ~clear_mask;
    end
    if (restart) begin
      cause_d = '0;
    end
    cause_d = cause_d | set_bits;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cause_q <= CAUSE_RST;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign cause_out = {(8 - CAUSE_W)'(0), cause_q};

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches watchdog/software reset requests, then releases the peripheral
// reset and, after a stagger, the CPU reset; records the cause of the latest reset.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       power_on_reset_n,
  input  logic       reset_req,
  input  logic [1:0] cause_in,
  input  logic       soft_write,
  input  logic [7:0] soft_data,
  input  logic       clear_write,
  input  logic [7:0] clear_data,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       busy,
  output logic [7:0] cause_out
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               periph_reset_q, periph_reset_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               busy_q, busy_d;

  logic               soft_req;
  logic               req;
  logic               restart;
  logic [CAUSE_W-1:0] set_bits;
  logic               unused_data_bits;

  assign soft_req         = soft_write & soft_data[0];
  assign req              = reset_req | soft_req;
  assign restart          = req & (state_q != ST_HOLD);
  assign unused_data_bits = ^{soft_data[7:1], clear_data[7:4]};

  // New cause bits; a watchdog request with no type bits is a forwarded power-on reset.
  always_comb begin
    set_bits             = '0;
    set_bits[CAUSE_POR]  = reset_req & (cause_in == 2'b00);
    set_bits[CAUSE_WDT]  = reset_req & cause_in[0];
    set_bits[CAUSE_TRAP] = reset_req & cause_in[1];
    set_bits[CAUSE_SOFT] = soft_req;
  end

  // Next state, counter and registered output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_HOLD: begin
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_STAGGER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STAGGER: begin
        if (req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STAGGER_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
    periph_reset_d = (state_d == ST_HOLD);
    cpu_reset_d    = (state_d != ST_RUN);
    busy_d         = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      periph_reset_q <= 1'b1;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      periph_reset_q <= periph_reset_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
    end
  end

  assign periph_reset = periph_reset_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;

  reset_cause_reg u_cause (
    .clk        (clk),
    .rst_n      (power_on_reset_n),
    .restart    (restart),
    .set_bits   (set_bits),
    .clear_en   (clear_write),
    .clear_mask (clear_data[CAUSE_W-1:0]),
    .cause_out  (cause_out)
  );

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the watchdog timer and consumes its combined reset request and its reset-type bits.
- Stretches every reset request to a guaranteed minimum pulse.
- Releases the two reset domains in order: peripheral reset first, then, after a stagger, CPU reset.
- Latches the cause of the most recent reset in an 8-bit I/O-readable register with write-1-to-clear semantics.
- Also accepts a software reset request from the I/O bus.

Parameters:
HOLD_CYCLES, 16, cycles during which both resets stay asserted (at least 1)
STAGGER_CYCLES, 8, cycles from peripheral reset release to CPU reset release (at least 1)
CNT_W, 8, counter width; must satisfy 2**CNT_W >= max(HOLD_CYCLES, STAGGER_CYCLES)

Ports:
clk  in  1  system clock; all logic is on its rising edge
power_on_reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
reset_req  in  1  active-high reset request from the watchdog (overflow, trap or power-on)
cause_in  in  2  watchdog reset-type bits: [0] = overflow, [1] = trap; sampled whenever reset_req is high
soft_write  in  1  I/O write strobe for the software-reset register
soft_data  in  8  I/O write data; bit0 = 1 requests a reset
clear_write  in  1  I/O write strobe for the cause register
clear_data  in  8  write-1-to-clear mask for cause bits [3:0]
periph_reset  out  1  active-high reset to the peripherals
cpu_reset  out  1  active-high reset to the CPU core
busy  out  1  high in any state other than RUN
cause_out  out  8  cause register: [0] POR, [1] watchdog overflow, [2] trap, [3] software; [7:4] read as 0

Behaviour:
- States: HOLD, STAGGER, RUN. State and counter are registered.
- Output decoding, from the state register only (no combinational path from any input):
  - HOLD: periph_reset = 1, cpu_reset = 1.
  - STAGGER: periph_reset = 0, cpu_reset = 1.
  - RUN: periph_reset = 0, cpu_reset = 0.
  - busy = (state != RUN).
- Request: req = reset_req | (soft_write & soft_data[0]).
- Power-on reset (power_on_reset_n low at a clock edge):
  - state = HOLD, cnt = 0, cause = 8'h01.
  - The power-on reset dominates all other inputs in that cycle.
- HOLD:
  - If req is high, cnt = 0 (retrigger) and the state stays HOLD.
  - Else if cnt == HOLD_CYCLES-1, go to STAGGER with cnt = 0.
  - Else cnt is incremented.
- STAGGER:
  - If req is high, go to HOLD with cnt = 0.
  - Else if cnt == STAGGER_CYCLES-1, go to RUN.
  - Else cnt is incremented.
- RUN: if req is high, go to HOLD with cnt = 0.
- Latency for the last request at edge t (counted in edges after t):
  - Both resets are high from edge t+1.
  - periph_reset falls at edge t+1+HOLD_CYCLES.
  - cpu_reset falls at edge t+1+HOLD_CYCLES+STAGGER_CYCLES.
- Cause register, on a req edge:
  - Entering HOLD from RUN or STAGGER: cause is first cleared to 0, then loaded with the new bits.
  - While already in HOLD: the new bits are ORed into cause.
  - New bits: [1] = reset_req & cause_in[0]; [2] = reset_req & cause_in[1]; [3] = soft request.
  - reset_req with cause_in == 0 sets bit0 (the watchdog is passing through a power-on reset).
- Cause clear:
  - clear_write clears the bits selected by clear_data[3:0].
  - If a set and a clear land on the same bit in the same cycle, the set wins.
  - A clear during HOLD is legal.
- Counter arithmetic: unsigned CNT_W bits; it never wraps, because the terminal compare always exits the state first.
- Simultaneous reset_req and soft request: both cause bits are set, with a single sequence.
- Reset values: periph_reset = 1, cpu_reset = 1, busy = 1, cause_out = 8'h01.

Decomposition:
- Shared package reset_pkg:
  - State enum.
  - Cause bit index constants CAUSE_POR = 0, CAUSE_WDT = 1, CAUSE_TRAP = 2, CAUSE_SOFT = 3.
- One sub-module: reset_cause_reg, which holds the 8-bit cause register with its set-wins-over-clear logic.
- The FSM and counter stay in the top module.

Test Plan:
- Power-on: hold power_on_reset_n low 3 cycles, then release.
  -> periph_reset falls 16 cycles after release; cpu_reset falls 8 cycles later; cause_out = 8'h01; busy falls together with cpu_reset.
- Watchdog overflow: in RUN, pulse reset_req for 1 cycle with cause_in = 2'b01.
  -> Both resets high the next cycle; cause_out = 8'h02; periph_reset low after 16 cycles, cpu_reset low after 24.
- Retrigger: second reset_req (cause_in = 2'b10) at HOLD cycle 10.
  -> HOLD restarts; periph_reset falls 16 cycles after the second pulse; cause_out = 8'h06.
- Request during STAGGER: soft_write with soft_data = 8'h01 at STAGGER cycle 3.
  -> periph_reset reasserts the next cycle; cause_out = 8'h08.
- Cause clear: in RUN with cause_out = 8'h06, write clear_data = 8'h02.
  -> cause_out = 8'h04.
- Set beats clear: in HOLD, the same cycle has clear_data = 8'h04 and reset_req with cause_in = 2'b10.
  -> Bit 2 remains set.
- Ignored write: soft_write with soft_data = 8'h00 in RUN.
  -> No state change; busy stays 0.
